btn_conditioner: RTL

- Input-conditioning stage that sits directly upstream of the stopwatch top level.
- Takes raw, asynchronous board buttons and switches: pause button, reset button, sel switch, adj switch.
- Produces clean, synchronized signals for the stopwatch core:
  - debounced sel/adj levels;
  - a pause-enable level that toggles once per press;
  - a single-cycle clear pulse.
- Every channel has a two-flop synchronizer and a stable-count debouncer, so mechanical bounce never reaches the counters.

---
 rtl/btn_conditioner.sv | 108 ++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// Button/switch conditioner in front of the stopwatch core. Each raw input is
// synchronized, debounced by a stable-count filter, and then turned into levels or strobes.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic pause_raw,
  input  logic clr_raw,
  input  logic sel_raw,
  input  logic adj_raw,
  output logic sel,
  output logic adj,
  output logic pause_en,
  output logic pause_pulse,
  output logic clr_pulse
);

  localparam int unsigned NCH      = 4;
  localparam int unsigned CH_PAUSE = 0;
  localparam int unsigned CH_CLR   = 1;
  localparam int unsigned CH_SEL   = 2;
  localparam int unsigned CH_ADJ   = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1_q;
  logic [NCH-1:0]   sync2_q;
  logic [NCH-1:0]   stable_q;
  logic [NCH-1:0]   stable_d;
  logic [NCH-1:0]   stable_dly_q;
  logic [NCH-1:0]   rise;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  logic pause_en_q;
  logic pause_en_d;
  logic pause_pulse_q;
  logic clr_pulse_q;

  assign raw = {adj_raw, sel_raw, clr_raw, pause_raw};

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; any agreeing sample restarts the count, so the counter never wraps.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = stable_q & ~stable_dly_q;

  // Clear wins over a simultaneous pause press.
  always_comb begin
    pause_en_d = pause_en_q;
    if (rise[CH_CLR]) begin
      pause_en_d = 1'b0;
    end else if (rise[CH_PAUSE]) begin
      pause_en_d = ~pause_en_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_dly_q  <= '0;
      pause_en_q    <= 1'b0;
      pause_pulse_q <= 1'b0;
      clr_pulse_q   <= 1'b0;
      // NOTE: the counter array is reset too, so a press in flight at reset is discarded.
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so the two-flop chain really is two flops.
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_dly_q  <= stable_q;
      pause_en_q    <= pause_en_d;
      pause_pulse_q <= rise[CH_PAUSE];
      clr_pulse_q   <= rise[CH_CLR];
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sel         = stable_q[CH_SEL];
  assign adj         = stable_q[CH_ADJ];
  assign pause_en    = pause_en_q;
  assign pause_pulse = pause_pulse_q;
  assign clr_pulse   = clr_pulse_q;

endmodule
